// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
package bcd_to_bin_pkg;

  localparam int unsigned BCD_DIGITS_DEF = 3;
  localparam int unsigned BCD_BIN_W_DEF  = 10;

  localparam logic [3:0] ADJ_SUB        = 4'd3;
  localparam logic [3:0] ADJ_THRESH     = 4'd8;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: subtract 3 from any digit of 8 or more.
module bcd_digit_sub3
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_SUB) : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional digit validity check enabled by BCD_TO_BIN_INVALID_CHECK_EN.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned DIGITS = BCD_DIGITS_DEF,
  parameter int unsigned BIN_W  = BCD_BIN_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + BIN_W;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              invalid_q, invalid_d;

  logic [SrW-1:0]    sr_shift;
  logic [BcdW-1:0]   bcd_adj;
  logic              bad_digit;

  assign sr_shift = sr_q >> 1;

  // Correction is applied to the already-shifted BCD field.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit_i (sr_shift[BIN_W + 4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD_TO_BIN_INVALID_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d      = {bcd_in, {BIN_W{1'b0}}};
          cnt_d     = CntW'(BIN_W);
          busy_d    = 1'b1;
          invalid_d = bad_digit;
          state_d   = StShift;
        end
      end
      StShift: begin
        sr_d  = {bcd_adj, sr_shift[BIN_W-1:0]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        bin_d   = invalid_q ? '0 : sr_q[BIN_W-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      bin_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  assign bin_out = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed, table-driven bench for bcd_to_bin (default 3 digits, 10-bit result).
module tb_bcd_to_bin;

  logic        clock;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;
  logic        busy;
  logic        done;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  bcd_to_bin dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .invalid (invalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  exp;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts one conversion and returns edges from accept to done (0 if none in budget).
  task automatic run_conv(input logic [11:0] bcd, input logic hold_start, output int lat);
    bcd_in = bcd;
    start  = 1'b1;
    tick();
    start  = hold_start;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  vec_t vecs[8];
  int   lat;
  int   done_cnt;
  int   done_at;

  initial begin
    vecs[0] = '{bcd: 12'h000, exp: 10'd0};
    vecs[1] = '{bcd: 12'h255, exp: 10'd255};
    vecs[2] = '{bcd: 12'h999, exp: 10'd999};
    vecs[3] = '{bcd: 12'h128, exp: 10'd128};
    vecs[4] = '{bcd: 12'h042, exp: 10'd42};
    vecs[5] = '{bcd: 12'h100, exp: 10'd100};
    vecs[6] = '{bcd: 12'h001, exp: 10'd1};
    vecs[7] = '{bcd: 12'h567, exp: 10'd567};

    reset  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;
    repeat (3) tick();
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    for (int v = 0; v < 8; v++) begin
      run_conv(vecs[v].bcd, 1'b0, lat);
      check($sformatf("latency_%03h", vecs[v].bcd), 32'(lat), 32'd11);
      check($sformatf("bin_%03h", vecs[v].bcd), 32'(bin_out), 32'(vecs[v].exp));
      check($sformatf("inv_%03h", vecs[v].bcd), 32'(invalid), 32'd0);
      check($sformatf("busy_at_done_%03h", vecs[v].bcd), 32'(busy), 32'd0);
      tick();
      check($sformatf("done_pulse_%03h", vecs[v].bcd), 32'(done), 32'd0);
    end

    // Start re-pulsed mid-conversion must be ignored.
    bcd_in = 12'h255;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    done_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 4) begin
        bcd_in = 12'h001;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        check("ignore_bin", 32'(bin_out), 32'd255);
      end
    end
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_done_at",    32'(done_at),  32'd11);
    check("ignore_final_bin",  32'(bin_out),  32'd255);

    // Reset during SHIFT aborts with no done.
    bcd_in = 12'h999;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_bin_out", 32'(bin_out), 32'd0);
    check("abort_done",    32'(done),    32'd0);
    tick();
    reset    = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_conv(12'h100, 1'b0, lat);
    check("post_abort_lat", 32'(lat),     32'd11);
    check("post_abort_bin", 32'(bin_out), 32'd100);
    tick();

    // Start held high: a new conversion is accepted on the edge after done.
    run_conv(12'h042, 1'b1, lat);
    check("held_lat", 32'(lat),     32'd11);
    check("held_bin", 32'(bin_out), 32'd42);
    tick();
    check("held_rearm_busy", 32'(busy), 32'd1);
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    check("held_second_lat", 32'(lat),     32'd11);
    check("held_second_bin", 32'(bin_out), 32'd42);
    tick();

    // Reset wins over a simultaneous start.
    reset  = 1'b0;
    start  = 1'b1;
    bcd_in = 12'h999;
    tick();
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("rst_vs_start_idle", 32'(busy), 32'd0);

    // Non-BCD digit handling.
    run_conv(12'h0A5, 1'b0, lat);
    check("bad_lat", 32'(lat), 32'd11);
`ifdef BCD_TO_BIN_INVALID_CHECK_EN
    check("bad_invalid", 32'(invalid), 32'd1);
    check("bad_bin",     32'(bin_out), 32'd0);
`else
    check("bad_invalid", 32'(invalid), 32'd0);
`endif
    tick();
    run_conv(12'h042, 1'b0, lat);
    check("after_bad_lat",     32'(lat),     32'd11);
    check("after_bad_invalid", 32'(invalid), 32'd0);
    check("after_bad_bin",     32'(bin_out), 32'd42);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
